// File: rtl/rns_cmp_pipe.sv
// rtl/rns_cmp_pipe.sv - pipelined MSB-chunk-first magnitude comparator with valid/ready stream
module rns_cmp_pipe #(
    parameter int WIDTH = 6,
    parameter int CHUNK = 3,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             sgn,
    input  logic [TAGW-1:0]  tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             op_err,
    output logic [TAGW-1:0]  tag_out
);

    localparam int NSTAGE = (WIDTH + CHUNK - 1) / CHUNK;
    // Stages 0..NSTAGE-2 keep full stage state; the last stage registers the resolved result.
    localparam int NMID   = (NSTAGE > 1) ? NSTAGE - 1 : 1;

    // Chunk k, right-aligned; the LSB remainder chunk is clipped at bit 0.
    function automatic logic [WIDTH-1:0] chunk_of(input logic [WIDTH-1:0] x, input int k);
        int hi;
        int lo;
        logic [WIDTH-1:0] one;
        logic [WIDTH-1:0] mask;
        hi = WIDTH - 1 - k * CHUNK;
        lo = hi - CHUNK + 1;
        if (lo < 0) begin
            lo = 0;
        end
        one  = WIDTH'(1);
        mask = (one << (hi - lo + 1)) - one;
        return (x >> lo) & mask;
    endfunction

    logic en;

    // Intermediate stage registers
    logic             mid_v_q   [NMID];
    logic             mid_dec_q [NMID];
    logic             mid_gt_q  [NMID];
    logic [2:0]       mid_op_q  [NMID];
    logic [TAGW-1:0]  mid_tag_q [NMID];
    logic [WIDTH-1:0] mid_a_q   [NMID];
    logic [WIDTH-1:0] mid_b_q   [NMID];

    // Output registers
    logic             out_valid_q;
    logic             result_q;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;
    logic             op_err_q;
    logic [TAGW-1:0]  tag_out_q;

    // Per-stage inputs and compare outputs
    logic             st_v      [NSTAGE];
    logic             st_dec_in [NSTAGE];
    logic             st_gt_in  [NSTAGE];
    logic [2:0]       st_op     [NSTAGE];
    logic [TAGW-1:0]  st_tag    [NSTAGE];
    logic [WIDTH-1:0] st_a      [NSTAGE];
    logic [WIDTH-1:0] st_b      [NSTAGE];
    logic             st_dec_d  [NSTAGE];
    logic             st_gt_d   [NSTAGE];

    logic             fin_gt_d;
    logic             fin_eq_d;
    logic             fin_lt_d;
    logic             fin_result_d;
    logic             fin_err_d;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign op_err    = op_err_q;
    assign tag_out   = tag_out_q;

    // Route each stage's inputs and compare its chunk; signed mode flips the MSB once on entry.
    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            if (k == 0) begin
                st_v[k]      = in_valid;
                st_dec_in[k] = 1'b0;
                st_gt_in[k]  = 1'b0;
                st_op[k]     = op;
                st_tag[k]    = tag;
                st_a[k]      = a ^ {sgn, {(WIDTH-1){1'b0}}};
                st_b[k]      = b ^ {sgn, {(WIDTH-1){1'b0}}};
            end else begin
                st_v[k]      = mid_v_q[k-1];
                st_dec_in[k] = mid_dec_q[k-1];
                st_gt_in[k]  = mid_gt_q[k-1];
                st_op[k]     = mid_op_q[k-1];
                st_tag[k]    = mid_tag_q[k-1];
                st_a[k]      = mid_a_q[k-1];
                st_b[k]      = mid_b_q[k-1];
            end
            st_dec_d[k] = st_dec_in[k];
            st_gt_d[k]  = st_gt_in[k];
            if (!st_dec_in[k]) begin
                if (chunk_of(st_a[k], k) > chunk_of(st_b[k], k)) begin
                    st_dec_d[k] = 1'b1;
                    st_gt_d[k]  = 1'b1;
                end else if (chunk_of(st_a[k], k) < chunk_of(st_b[k], k)) begin
                    st_dec_d[k] = 1'b1;
                    st_gt_d[k]  = 1'b0;
                end else begin
                    st_dec_d[k] = 1'b0;
                    st_gt_d[k]  = 1'b0;
                end
            end
        end
    end

    // Resolve the last stage's ordering into the selected relation.
    always_comb begin
        fin_gt_d     = st_dec_d[NSTAGE-1] && st_gt_d[NSTAGE-1];
        fin_lt_d     = st_dec_d[NSTAGE-1] && !st_gt_d[NSTAGE-1];
        fin_eq_d     = !st_dec_d[NSTAGE-1];
        fin_err_d    = 1'b0;
        fin_result_d = 1'b0;
        case (st_op[NSTAGE-1])
            3'd0:    fin_result_d = fin_gt_d || fin_eq_d;
            3'd1:    fin_result_d = fin_gt_d;
            3'd2:    fin_result_d = fin_eq_d;
            3'd3:    fin_result_d = !fin_eq_d;
            3'd4:    fin_result_d = fin_lt_d || fin_eq_d;
            3'd5:    fin_result_d = fin_lt_d;
            default: fin_err_d    = 1'b1;
        endcase
    end

    // Valid bits and output registers: cleared by reset, advance together when enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NMID; k++) begin
                mid_v_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            result_q    <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            op_err_q    <= 1'b0;
            tag_out_q   <= '0;
        end else if (en) begin
            for (int k = 0; k < NSTAGE - 1; k++) begin
                mid_v_q[k] <= st_v[k];
            end
            out_valid_q <= st_v[NSTAGE-1];
            result_q    <= fin_result_d;
            gt_q        <= fin_gt_d;
            eq_q        <= fin_eq_d;
            lt_q        <= fin_lt_d;
            op_err_q    <= fin_err_d;
            tag_out_q   <= st_tag[NSTAGE-1];
        end
    end

    // Intermediate datapath registers: no reset needed, their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < NSTAGE - 1; k++) begin
                mid_dec_q[k] <= st_dec_d[k];
                mid_gt_q[k]  <= st_gt_d[k];
                mid_op_q[k]  <= st_op[k];
                mid_tag_q[k] <= st_tag[k];
                mid_a_q[k]   <= st_a[k];
                mid_b_q[k]   <= st_b[k];
            end
        end
    end

endmodule

// File: tb/tb_rns_cmp_pipe.sv
// tb/tb_rns_cmp_pipe.sv - self-checking bench for rns_cmp_pipe
module tb_rns_cmp_pipe;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, out_valid, out_ready;
    logic [5:0] a, b;
    logic [2:0] op;
    logic       sgn;
    logic [3:0] tag, tag_out;
    logic       result, gt, eq, lt, op_err;

    logic       in_valid2, in_ready2, out_valid2, out_ready2;
    logic [6:0] a2, b2;
    logic [2:0] op2;
    logic       sgn2;
    logic [3:0] tag2, tag_out2;
    logic       result2, gt2, eq2, lt2, op_err2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rns_cmp_pipe #(.WIDTH(6), .CHUNK(3), .TAGW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .sgn(sgn), .tag(tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .gt(gt), .eq(eq), .lt(lt), .op_err(op_err), .tag_out(tag_out)
    );

    rns_cmp_pipe #(.WIDTH(7), .CHUNK(3), .TAGW(4)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .op(op2), .sgn(sgn2), .tag(tag2),
        .out_valid(out_valid2), .out_ready(out_ready2), .result(result2),
        .gt(gt2), .eq(eq2), .lt(lt2), .op_err(op_err2), .tag_out(tag_out2)
    );

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic [2:0] op;
        logic       sgn;
        logic [4:0] exp;   // {result, gt, eq, lt, op_err}
    } vec_t;

    typedef struct {
        logic [4:0] exp;
        logic [3:0] tag;
    } sb_t;

    sb_t  sbq[$];
    sb_t  sbq2[$];
    int   got_tags[$];
    bit   chk_ready_en = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Relation from plain integer arithmetic on the operand values.
    function automatic logic [4:0] model(input longint ua, input longint ub, input int rop,
                                         input bit s, input int w);
        longint sa, sb;
        logic g, e, l, r, err;
        sa = ua;
        sb = ub;
        if (s && ua >= (longint'(1) << (w - 1))) sa = ua - (longint'(1) << w);
        if (s && ub >= (longint'(1) << (w - 1))) sb = ub - (longint'(1) << w);
        g = sa > sb;
        e = sa == sb;
        l = sa < sb;
        err = 1'b0;
        case (rop)
            0: r = g | e;
            1: r = g;
            2: r = e;
            3: r = !e;
            4: r = l | e;
            5: r = l;
            default: begin r = 1'b0; err = 1'b1; end
        endcase
        return {r, g, e, l, err};
    endfunction

    function automatic logic [4:0] dut_pack();
        return {result, gt, eq, lt, op_err};
    endfunction

    // One cycle on the 6-bit instance with scoreboard bookkeeping and stall-stability checking.
    task automatic tick();
        logic       stall;
        logic [4:0] snap;
        logic [3:0] snap_tag;
        sb_t        e;
        #1;
        if (chk_ready_en) chk("in_ready_mirror", in_ready, !out_valid || out_ready);
        if (in_valid && in_ready) begin
            e.exp = model(longint'(a), longint'(b), int'(op), sgn, 6);
            e.tag = tag;
            sbq.push_back(e);
        end
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("stream_unexpected_out", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("stream_flags", dut_pack(), e.exp);
                chk("stream_tag", tag_out, e.tag);
                got_tags.push_back(int'(tag_out));
            end
        end
        stall    = out_valid && !out_ready;
        snap     = dut_pack();
        snap_tag = tag_out;
        @(posedge clk);
        #1;
        if (stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_flags", dut_pack(), snap);
            chk("stall_tag", tag_out, snap_tag);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sbq.size() > 0; i++) tick();
        chk("drain_empty", sbq.size(), 0);
    endtask

    vec_t vecs[12];

    initial begin
        int n_acc;
        int wait_n;

        vecs[0]  = '{6'd45, 6'd45, 3'd0, 1'b0, 5'b10100};
        vecs[1]  = '{6'd44, 6'd45, 3'd0, 1'b0, 5'b00010};
        vecs[2]  = '{6'd32, 6'd31, 3'd5, 1'b1, 5'b10010};
        vecs[3]  = '{6'd32, 6'd31, 3'd5, 1'b0, 5'b01000};
        vecs[4]  = '{6'd5,  6'd3,  3'd6, 1'b0, 5'b01001};
        vecs[5]  = '{6'd0,  6'd63, 3'd1, 1'b0, 5'b00010};
        vecs[6]  = '{6'd63, 6'd63, 3'd3, 1'b0, 5'b00100};
        vecs[7]  = '{6'd63, 6'd0,  3'd4, 1'b1, 5'b10010};
        vecs[8]  = '{6'd7,  6'd56, 3'd2, 1'b0, 5'b00010};
        vecs[9]  = '{6'd9,  6'd8,  3'd7, 1'b0, 5'b01001};
        vecs[10] = '{6'd40, 6'd41, 3'd4, 1'b0, 5'b10010};
        vecs[11] = '{6'd20, 6'd20, 3'd1, 1'b1, 5'b00100};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0; sgn = 1'b0; tag = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0; op2 = '0; sgn2 = 1'b0; tag2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_flags", dut_pack(), 0);
        chk("reset_tag_out", tag_out, 0);
        chk("reset_in_ready", in_ready, 1);

        // Directed table: one pair at a time, exact latency of 2.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; op = vecs[i].op;
            sgn = vecs[i].sgn; tag = 4'(i);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("vec_lat1_valid", out_valid, 0);
            @(posedge clk);
            #1;
            chk("vec_lat2_valid", out_valid, 1);
            chk($sformatf("vec%0d_flags", i), dut_pack(), vecs[i].exp);
            chk($sformatf("vec%0d_tag", i), tag_out, i);
        end
        @(posedge clk);
        #1;

        // Exhaustive 64x64 over all six ops, streaming at full rate.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int ia = 0; ia < 64; ia++) begin
            for (int ib = 0; ib < 64; ib++) begin
                for (int io = 0; io < 6; io++) begin
                    a = 6'(ia); b = 6'(ib); op = 3'(io);
                    sgn = 1'($urandom_range(0, 1));
                    tag = 4'($urandom);
                    tick();
                end
            end
        end
        drain();

        // Random traffic with random back-pressure, reserved ops included.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            a = 6'($urandom); b = 6'($urandom); op = 3'($urandom);
            sgn = 1'($urandom); tag = 4'($urandom);
            tick();
        end
        drain();

        // Ten tagged pairs under a 1,0,0,1 out_ready pattern.
        got_tags.delete();
        chk_ready_en = 1;
        n_acc = 0;
        for (int cyc = 0; cyc < 200 && (n_acc < 10 || sbq.size() > 0); cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (n_acc < 10);
            tag = 4'(n_acc);
            a = 6'($urandom); b = 6'($urandom); op = 3'($urandom_range(0, 5));
            sgn = 1'($urandom);
            #1;
            if (in_valid && in_ready) n_acc++;
            tick();
        end
        chk_ready_en = 0;
        chk("bp_count", got_tags.size(), 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_tag%0d", i), (i < got_tags.size()) ? got_tags[i] : -1, i);
        end
        drain();

        // Reset while two pairs are in flight.
        out_ready = 1'b1;
        in_valid = 1'b1; a = 6'd10; b = 6'd3; op = 3'd1; sgn = 1'b0; tag = 4'd1;
        @(posedge clk);
        #1;
        tag = 4'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_no_valid", out_valid, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1; a = 6'd2; b = 6'd9; op = 3'd5; tag = 4'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_n = 0;
        while (!out_valid && wait_n < 10) begin
            @(posedge clk);
            #1;
            wait_n++;
        end
        chk("rst_mid_timeout", (wait_n < 10), 1);
        chk("rst_mid_first_tag", tag_out, 7);
        chk("rst_mid_result", result, 1);
        @(posedge clk);
        #1;

        // WIDTH=7 instance: remainder chunk, latency 3.
        in_valid2 = 1'b1; a2 = 7'h41; b2 = 7'h40; op2 = 3'd1; sgn2 = 1'b0; tag2 = 4'd3;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        chk("w7_lat1_valid", out_valid2, 0);
        @(posedge clk);
        #1;
        chk("w7_lat2_valid", out_valid2, 0);
        @(posedge clk);
        #1;
        chk("w7_lat3_valid", out_valid2, 1);
        chk("w7_result", result2, 1);
        chk("w7_gt", gt2, 1);
        chk("w7_tag", tag_out2, 3);
        @(posedge clk);
        #1;

        // WIDTH=7 random stream against the model.
        for (int i = 0; i < 320; i++) begin
            sb_t e;
            in_valid2 = (i < 300);
            a2 = 7'($urandom); b2 = 7'($urandom); op2 = 3'($urandom);
            sgn2 = 1'($urandom); tag2 = 4'($urandom);
            #1;
            if (in_valid2 && in_ready2) begin
                e.exp = model(longint'(a2), longint'(b2), int'(op2), sgn2, 7);
                e.tag = tag2;
                sbq2.push_back(e);
            end
            if (out_valid2 && out_ready2) begin
                if (sbq2.size() == 0) begin
                    chk("w7_unexpected_out", 1, 0);
                end else begin
                    e = sbq2.pop_front();
                    chk("w7_stream_flags", {result2, gt2, eq2, lt2, op_err2}, e.exp);
                    chk("w7_stream_tag", tag_out2, e.tag);
                end
            end
            @(posedge clk);
            #1;
        end
        chk("w7_drain_empty", sbq2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rns_cmp_pipe.md
# rns_cmp_pipe

Parametrised, pipelined magnitude comparator for residue-channel datapaths, replacing fixed-width single-cycle greater-or-equal compare logic. Each operand pair is compared MSB-chunk-first across a register pipeline, one CHUNK-bit slice per stage, and then resolved to one of six relational results. Operands can be unsigned or two's-complement. The block sits between residue arithmetic units and modular-correction logic, and uses a valid/ready stream interface with full back-pressure.

## Interface
- WIDTH, default 6: operand width in bits; legal range 2..64.
- CHUNK, default 3: bits compared per pipeline stage; legal range 1..WIDTH. NSTAGE = ceil(WIDTH/CHUNK).
- TAGW, default 4: width of the user tag carried alongside each operand pair.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst_n  in  1  reset, active-low. Synchronous: sampled only on the rising edge of clk.
- in_valid  in  1  an operand pair is presented.
- in_ready  out  1  the block accepts the pair this cycle.
- a  in  WIDTH  left operand.
- b  in  WIDTH  right operand.
- op  in  3  relation: 0=GE, 1=GT, 2=EQ, 3=NE, 4=LE, 5=LT; 6 and 7 are reserved.
- sgn  in  1  1 = two's-complement compare; 0 = unsigned compare.
- tag  in  TAGW  user tag, returned unchanged with the result.
- out_valid  out  1  a result is presented.
- out_ready  in  1  the downstream stage accepts the result.
- result  out  1  value of the relation `a op b`.
- gt, eq, lt  out  1 each  raw ordering flags, one-hot.
- op_err  out  1  op was reserved; result is forced to 0.
- tag_out  out  TAGW  the tag captured with the pair.

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Pipeline enable: `en = !out_valid || out_ready`. The pipeline is global: all stages advance together when en=1 and all hold when en=0. in_ready = en.
- Each stage k (k=0 is the MSB end) holds:
  - valid bit;
  - operands;
  - op, sgn, tag;
  - decided flag;
  - gt flag.
- Chunk rules:
  - Chunk k covers bits [WIDTH-1-k*CHUNK -: CHUNK].
  - The last chunk is the LSB remainder, of width WIDTH - (NSTAGE-1)*CHUNK. It may be narrower than CHUNK and must not index below bit 0.
- Stage logic:
  - If the incoming pair is already decided, pass decided and gt through unchanged.
  - Otherwise compare chunk k:
    - a-chunk > b-chunk: decided=1, gt=1.
    - a-chunk < b-chunk: decided=1, gt=0.
    - equal: decided=0.
- Signed mode (sgn=1): stage 0 inverts bit WIDTH-1 of both operands before comparing. All other bits are compared unsigned.
- Final resolution, registered at the last stage:
  - gt = decided && gt_flag.
  - lt = decided && !gt_flag.
  - eq = !decided.
  - result is selected by op from {gt|eq, gt, eq, !eq, lt|eq, lt}.
  - Reserved op: result=0 and op_err=1; gt/eq/lt are still reported.
- Ordering: results emerge in input order. No pair is dropped or duplicated under any out_ready pattern.

## Timing
- Latency: NSTAGE cycles from input transfer to out_valid, with no back-pressure. With defaults, NSTAGE=2.
- Throughput: one pair per cycle while out_ready=1.
- Stall behaviour: when out_valid=1 and out_ready=0:
  - in_ready=0;
  - all outputs hold stable;
  - every stage holds.
- Simultaneous events: a pair can be accepted in the same cycle that a full-pipeline result drains, because en=1.
- Reset, when rst_n is sampled low:
  - all stage valid bits clear;
  - out_valid=0, result=0, gt=0, eq=0, lt=0, op_err=0, tag_out=0;
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation discards every in-flight pair; no partial result is emitted afterwards.
- Datapath registers other than valid bits and outputs need no reset.

## Test plan
- Unsigned sweep (WIDTH=6, CHUNK=3, out_ready=1): a=45, b=45, op=GE.
  - After 2 cycles: result=1, eq=1, gt=0, lt=0.
  - a=44, b=45, op=GE: result=0, lt=1.
  - Exhaustive 64×64 over all six ops must match a behavioural model.
- Signed mode (sgn=1): a=6'b100000 (-32), b=6'b011111 (+31), op=LT → result=1, lt=1. The same operands with sgn=0 → result=0, gt=1.
- Remainder chunk (WIDTH=7, CHUNK=3, NSTAGE=3): a=7'h41, b=7'h40, op=GT.
  - The LSB-only difference resolves in the 1-bit last chunk: result=1, latency 3.
- Back-pressure: stream 10 pairs with tags 0..9 while out_ready toggles 1,0,0,1 repeatedly.
  - tag_out sequence is exactly 0..9.
  - Outputs are stable during every out_ready=0 cycle.
  - in_ready mirrors en.
- Reserved op: op=6, a=5, b=3 → result=0, op_err=1, gt=1.
- Reset mid-stream: drive rst_n low for 1 cycle while 2 pairs are in flight.
  - out_valid stays 0 until a new pair is accepted.
  - The first result after reset carries the new tag.
